// File: rtl/bpd_update_arbiter_pkg.sv
// Shared types and helpers for the BPD update arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bpd_arb_pkg;

  localparam int BPD_ARB_MAX_IN = 8;

  typedef logic [7:0] wait_cnt_t;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest-index set bit as a one-hot vector (all-zero when nothing is set).
  function automatic logic [BPD_ARB_MAX_IN-1:0] prio_pick(input logic [BPD_ARB_MAX_IN-1:0] valid);
    logic [BPD_ARB_MAX_IN-1:0] pick;
    pick = '0;
    for (int i = BPD_ARB_MAX_IN - 1; i >= 0; i--) begin
      if (valid[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bpd_update_arbiter_if.sv
// Request/response bundle between update sources, the arbiter and the BPD port.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the per-channel input side and the output side.
interface bpd_update_arbiter_if #(
  parameter int N_IN      = 2,
  parameter int PAYLOAD_W = 512
);
  import bpd_arb_pkg::*;

  localparam int IDX_W = idx_w(N_IN);

  logic [N_IN-1:0]           io_in_valid;
  logic [N_IN-1:0]           io_in_ready;
  logic [N_IN*PAYLOAD_W-1:0] io_in_bits;
  logic                      io_out_valid;
  logic                      io_out_ready;
  logic [PAYLOAD_W-1:0]      io_out_bits;
  logic [IDX_W-1:0]          io_out_chosen;
  logic                      io_out_starved;

  // Environment side: update sources plus the downstream BPD port.
  modport master (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_chosen, io_out_starved
  );

  // Arbiter side.
  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_out_chosen, io_out_starved
  );

endinterface

// File: rtl/bpd_update_arbiter_out_reg.sv
// One-entry valid/ready pipeline register (module bpd_arb_out_reg).
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: accepts when empty or draining in the same cycle, so full throughput.
module bpd_arb_out_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  assign o_rdy = ~r_vld | i_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_dat;

  // Load on an input handshake (reload without bubble), empty after a drain, otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_vld && o_rdy) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/bpd_update_arbiter.sv
// N-way fixed-priority arbiter for BPD updates with optional aging (BPD_ARB_STARVE_EN).
// Latency: 1 cycle, input handshake at t -> io_out_valid/bits at t+1.
// Backpressure: only the granted channel sees ready, and only when the output register can load.
module bpd_update_arbiter
  import bpd_arb_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int PAYLOAD_W  = 512,
  parameter int STARVE_MAX = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  bpd_update_arbiter_if.slave    io
);

  localparam int IDX_W = idx_w(N_IN);
  localparam int ENT_W = 1 + IDX_W + PAYLOAD_W;

  if (N_IN < 2 || N_IN > BPD_ARB_MAX_IN || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_cfg
    $error("bpd_update_arbiter: N_IN must be 2..8 and STARVE_MAX 1..255");
  end

  logic                 w_load;
  logic [N_IN-1:0]      w_promo;
  logic [N_IN-1:0]      w_grant;
  logic                 w_starved;
  logic [N_IN-1:0]      w_hs;
  logic                 w_any_hs;
  logic [IDX_W-1:0]     w_idx;
  logic [PAYLOAD_W-1:0] w_sel;
  logic [ENT_W-1:0]     w_ent_in;
  logic [ENT_W-1:0]     w_ent_out;

`ifdef BPD_ARB_STARVE_EN
  wait_cnt_t r_wait_cnt [N_IN];

  // A waiting channel that has lost STARVE_MAX handshakes jumps ahead of static priority.
  always_comb begin
    w_promo = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_promo[i] = io.io_in_valid[i] && (r_wait_cnt[i] == wait_cnt_t'(STARVE_MAX));
    end
  end

  // Age only on handshakes won by someone else; dropping valid forfeits accumulated wait.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) r_wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (!io.io_in_valid[i] || w_hs[i]) begin
          r_wait_cnt[i] <= '0;
        end else if (w_any_hs && (r_wait_cnt[i] != wait_cnt_t'(STARVE_MAX))) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign w_promo = '0;
`endif

  // Promoted channels win first (lowest index among them), else plain lowest-index valid.
  always_comb begin
    w_starved = |w_promo;
    if (w_starved) begin
      w_grant = N_IN'(prio_pick(BPD_ARB_MAX_IN'(w_promo)));
    end else begin
      w_grant = N_IN'(prio_pick(BPD_ARB_MAX_IN'(io.io_in_valid)));
    end
  end

  // Encode the one-hot grant and steer the matching payload slice.
  always_comb begin
    w_idx = '0;
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant[i]) begin
        w_idx = IDX_W'(i);
        w_sel = io.io_in_bits[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Ready is forced low while reset is held so nothing is accepted into a clearing stage.
  assign io.io_in_ready = w_grant & {N_IN{w_load & reset}};
  assign w_hs           = io.io_in_valid & io.io_in_ready;
  assign w_any_hs       = |w_hs;
  assign w_ent_in       = {w_starved, w_idx, w_sel};

  bpd_arb_out_reg #(
    .W (ENT_W)
  ) u_out_reg (
    .clock (clock),
    .reset (reset),
    .i_vld (w_any_hs),
    .o_rdy (w_load),
    .i_dat (w_ent_in),
    .o_vld (io.io_out_valid),
    .i_rdy (io.io_out_ready),
    .o_dat (w_ent_out)
  );

  assign io.io_out_starved = w_ent_out[ENT_W-1];
  assign io.io_out_chosen  = w_ent_out[PAYLOAD_W +: IDX_W];
  assign io.io_out_bits    = w_ent_out[PAYLOAD_W-1:0];

endmodule

// File: tb/tb_bpd_update_arbiter.sv
// Scoreboard bench for bpd_update_arbiter (N_IN=3, PAYLOAD_W=16, STARVE_MAX=3).
// Expected entries come from a reference model of grant/aging evaluated as stimulus is applied.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_bpd_update_arbiter;
  import bpd_arb_pkg::*;

  localparam int N  = 3;
  localparam int PW = 16;
  localparam int SM = 3;
`ifdef BPD_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef struct packed {
    logic          starved;
    logic [1:0]    chosen;
    logic [PW-1:0] bits;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bpd_update_arbiter_if #(.N_IN(N), .PAYLOAD_W(PW)) io();

  bpd_update_arbiter #(.N_IN(N), .PAYLOAD_W(PW), .STARVE_MAX(SM)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  ent_t exp_q[$];
  ent_t obs_q[$];
  ent_t obs_cur;
  logic [N-1:0] obs_ready, exp_ready;
  logic obs_vld, exp_vld;
  int   m_cnt [N];
  logic m_vld;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [N*PW-1:0] mk_bits(input int k);
    return {16'(32'h2000 + k), 16'(32'h1000 + k), 16'(k)};
  endfunction

  // One clock: sample at negedge, run the reference model, queue expected and observed entries.
  task automatic tick();
    logic [N-1:0] src, prom, hs;
    logic promo, load;
    int g;
    ent_t e;
    @(negedge clock);
    obs_ready = io.io_in_ready;
    obs_vld   = io.io_out_valid;
    obs_cur   = {io.io_out_starved, io.io_out_chosen, io.io_out_bits};
    exp_vld   = m_vld;
    src  = io.io_in_valid;
    prom = '0;
    promo = 1'b0;
    if (STARVE_ON) begin
      for (int i = 0; i < N; i++) prom[i] = io.io_in_valid[i] && (m_cnt[i] == SM);
      if (prom != '0) begin src = prom; promo = 1'b1; end
    end
    g = -1;
    for (int i = N - 1; i >= 0; i--) if (src[i]) g = i;
    load = !m_vld || io.io_out_ready;
    exp_ready = '0;
    if (reset && load && g >= 0) exp_ready[g] = 1'b1;
    hs = io.io_in_valid & exp_ready;
    if (reset && obs_vld && io.io_out_ready) obs_q.push_back(obs_cur);
    if (hs != '0) begin
      e = {promo, 2'(g), io.io_in_bits[g*PW +: PW]};
      exp_q.push_back(e);
    end
    if (!reset) begin
      m_vld = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (hs != '0) m_vld = 1'b1;
      else if (io.io_out_ready) m_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!io.io_in_valid[i] || hs[i]) m_cnt[i] = 0;
        else if (hs != '0 && m_cnt[i] < SM) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    io.io_in_valid  = 3'b111;
    io.io_in_bits   = mk_bits(7);
    io.io_out_ready = 1'b1;
    #12;
    n_checks++; if (io.io_in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 000", io.io_in_ready); end
    n_checks++; if (io.io_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", io.io_out_valid); end
    n_checks++; if (io.io_out_bits !== 16'h0) begin n_fail++; $display("FAIL reset_out_bits: got %h want 0000", io.io_out_bits); end
    n_checks++; if (io.io_out_chosen !== 2'd0) begin n_fail++; $display("FAIL reset_out_chosen: got %0d want 0", io.io_out_chosen); end
    n_checks++; if (io.io_out_starved !== 1'b0) begin n_fail++; $display("FAIL reset_out_starved: got %b want 0", io.io_out_starved); end
    io.io_in_valid = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    ent_t o, e;
    int n1;
    n1 = 0;
    io.io_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      io.io_in_valid = 3'b011;
      io.io_in_bits  = mk_bits(k);
      tick();
      if (obs_ready[1]) n1++;
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL contention_ready k=%0d: got %b want %b", k, obs_ready, exp_ready); end
      n_checks++; if (obs_vld !== exp_vld) begin n_fail++; $display("FAIL contention_out_valid k=%0d: got %b want %b", k, obs_vld, exp_vld); end
    end
    io.io_in_valid = 3'b000;
    tick();
    tick();
    n_checks++; if (n1 !== (STARVE_ON ? 4 : 0)) begin n_fail++; $display("FAIL contention_ch1_grants: got %0d want %0d", n1, STARVE_ON ? 4 : 0); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL contention_sb: got %h want nothing", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL contention_sb: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_single();
    ent_t o, e;
    io.io_out_ready = 1'b1;
    io.io_in_valid  = 3'b100;
    io.io_in_bits   = {16'h00A5, 16'h0000, 16'h0000};
    tick();
    n_checks++; if (obs_ready !== 3'b100) begin n_fail++; $display("FAIL single_ready: got %b want 100", obs_ready); end
    io.io_in_valid = 3'b000;
    tick();
    n_checks++; if (obs_vld !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", obs_vld); end
    n_checks++; if (obs_cur.bits !== 16'h00A5) begin n_fail++; $display("FAIL single_out_bits: got %h want 00a5", obs_cur.bits); end
    n_checks++; if (obs_cur.chosen !== 2'd2) begin n_fail++; $display("FAIL single_out_chosen: got %0d want 2", obs_cur.chosen); end
    n_checks++; if (obs_cur.starved !== 1'b0) begin n_fail++; $display("FAIL single_out_starved: got %b want 0", obs_cur.starved); end
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_sb: got %h want nothing", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL single_sb: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_backpressure();
    ent_t o, e;
    io.io_out_ready = 1'b1;
    io.io_in_valid  = 3'b111;
    io.io_in_bits   = mk_bits(16'h40);
    tick();
    io.io_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      io.io_in_bits = mk_bits(16'h50 + k);
      tick();
      n_checks++; if (obs_ready !== 3'b000 || exp_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready k=%0d: got %b want 000", k, obs_ready); end
      n_checks++; if (obs_vld !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid k=%0d: got %b want 1", k, obs_vld); end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_hold k=%0d: got %h want a queued entry", k, obs_cur); end
      else if (obs_cur !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold k=%0d: got %h want %h", k, obs_cur, exp_q[0]); end
    end
    io.io_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      io.io_in_bits = mk_bits(16'h60 + k);
      tick();
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL bp_release_ready k=%0d: got %b want %b", k, obs_ready, exp_ready); end
    end
    io.io_in_valid = 3'b000;
    tick();
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_sb: got %h want nothing", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL bp_sb: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_back_to_back();
    ent_t o, e;
    io.io_out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        io.io_in_valid = 3'b001;
        io.io_in_bits  = {16'h0000, 16'h0000, 16'(32'hB000 + k)};
      end else begin
        io.io_in_valid = 3'b000;
      end
      tick();
      n_checks++; if (obs_vld !== (k != 0)) begin n_fail++; $display("FAIL b2b_out_valid k=%0d: got %b want %b", k, obs_vld, k != 0); end
      if (k >= 1) begin
        n_checks++; if (obs_cur.bits !== 16'(32'hB000 + k - 1)) begin n_fail++; $display("FAIL b2b_out_bits k=%0d: got %h want %h", k, obs_cur.bits, 16'(32'hB000 + k - 1)); end
      end
    end
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb: got %h want nothing", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_reset_mid();
    ent_t o, e;
    io.io_out_ready = 1'b0;
    io.io_in_valid  = 3'b010;
    io.io_in_bits   = {16'h0000, 16'h5A5A, 16'h0000};
    tick();
    n_checks++; if (io.io_out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_loaded: got %b want 1", io.io_out_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (io.io_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_valid: got %b want 0", io.io_out_valid); end
    n_checks++; if (io.io_out_bits !== 16'h0) begin n_fail++; $display("FAIL rmid_async_bits: got %h want 0000", io.io_out_bits); end
    n_checks++; if (io.io_in_ready !== 3'b000) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 000", io.io_in_ready); end
    m_vld = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    exp_q.delete();
    obs_q.delete();
    tick();
    n_checks++; if (obs_ready !== 3'b000) begin n_fail++; $display("FAIL rmid_held_ready: got %b want 000", obs_ready); end
    io.io_in_valid = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    io.io_out_ready = 1'b1;
    tick();
    n_checks++; if (obs_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_after_release: got %b want 0", obs_vld); end
    io.io_in_valid = 3'b100;
    io.io_in_bits  = {16'h0077, 16'h0000, 16'h0000};
    tick();
    io.io_in_valid = 3'b000;
    tick();
    n_checks++; if (obs_vld !== 1'b1 || obs_cur.chosen !== 2'd2 || obs_cur.bits !== 16'h0077) begin
      n_fail++; $display("FAIL rmid_new_output: got v=%b ch=%0d bits=%h want v=1 ch=2 bits=0077", obs_vld, obs_cur.chosen, obs_cur.bits);
    end
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rmid_sb: got %h want nothing", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rmid_sb: got %h want %h", o, e); end end
    end
  endtask

  initial begin
    io.io_in_valid  = '0;
    io.io_in_bits   = '0;
    io.io_out_ready = 1'b0;
    m_vld = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d expected / %0d observed pending, want 0 / 0", exp_q.size(), obs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpd_update_arbiter.md
# bpd_update_arbiter

Parametrised N-way arbiter for branch-predictor update requests, with a registered output stage and optional anti-starvation aging. It sits between the update sources and the BPD update port. Typical sources are the mispredict/repair path and the commit path, plus prefetch or replay paths in wider configurations. It is the successor to the fixed two-input combinational priority arbiter: it adds channel-count and payload-width parameters, a one-cycle registered output with full throughput under backpressure, and grant aging so that low-priority commit updates cannot be starved forever.

## Interface
- N_IN, 2: number of requesting channels, 2..8; channel 0 has the highest static priority.
- PAYLOAD_W, 512: width of one flattened update payload (pc, masks, cfi info, ghist, target, meta).
- STARVE_MAX, 15: wait threshold (in lost handshakes) at which a channel is promoted; 1..255.
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset; while low, all state is cleared.
- io_in_valid, input, N_IN, per-channel request valid.
- io_in_ready, output, N_IN, per-channel accept; high only for the granted channel when the stage can load.
- io_in_bits, input, N_IN*PAYLOAD_W, payloads; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- io_out_valid, output, 1, registered output valid.
- io_out_ready, input, 1, downstream accept.
- io_out_bits, output, PAYLOAD_W, registered payload.
- io_out_chosen, output, clog2(N_IN), index of the channel whose payload is in the output register.
- io_out_starved, output, 1, the held entry was granted through starvation promotion (0 when the feature is compiled out).

## Operation
- Load condition: `load = ~io_out_valid | io_out_ready`.
- Grant selection (combinational):
  - If any valid channel has wait_cnt == STARVE_MAX, grant the lowest-index such channel.
  - Otherwise grant the lowest-index valid channel.
- `io_in_ready[i] = load & grant[i]`. At most one ready bit is high. Ready never depends on `io_in_valid[i]` of the same channel beyond the grant selection.
- Handshake on channel g (valid & ready) loads the output register on the next edge: bits, chosen = g, starved flag, and out_valid = 1.
- If `load` holds and no input is valid, the register empties when drained (out_valid → 0 after an out handshake).
- Aging, per channel i, using an 8-bit saturating `wait_cnt[i]`:
  - Cleared when channel i handshakes, or when `io_in_valid[i]` is low.
  - Incremented (saturating at STARVE_MAX) when `io_in_valid[i]` is high and another channel handshakes.
  - Held when no handshake occurs (backpressure does not age).
- Payload is passed through unmodified; the block performs no field interpretation.

## Timing
- Latency: input handshake at cycle t → io_out_valid/bits at t+1.
- Throughput: one transfer per cycle while io_out_ready stays high.
- Reset values: io_out_valid=0, io_out_bits=0, io_out_chosen=0, io_out_starved=0, all wait_cnt=0. io_in_ready is all-zero during reset.
- Simultaneous output drain and input handshake in the same cycle: the register reloads; there is no bubble.
- Output held stable (bits, chosen, starved) while io_out_valid & ~io_out_ready.
- Reset asserted mid-transfer: the held entry is discarded, and no partial state survives.
- Channel i deasserting valid before being granted clears its counter. There is no credit carry-over.

## Configuration
- BPD_ARB_STARVE_EN defined: the wait counters, the promotion path and io_out_starved are active as above.
- BPD_ARB_STARVE_EN undefined: the counters are removed and grant is pure lowest-index fixed priority, matching the legacy arbiter policy with the added output register. io_out_starved is tied 0.

## Structure
- Package bpd_arb_pkg:
  - `BPD_ARB_MAX_IN=8`.
  - Localparam function `idx_w(n)` (clog2, minimum 1).
  - Typedef `wait_cnt_t` (logic [7:0]).
  - Function `prio_pick(valid)` returning the lowest-index one-hot.
- Sub-module bpd_arb_out_reg: a one-entry valid/ready pipeline register carrying {starved, chosen, bits}, with async active-low reset. It is instantiated once.

## Test plan
- N_IN=2, both valid, io_out_ready=1 → chosen=0 every cycle; channel 1 starves until cnt=STARVE_MAX=3, then on the 4th contested cycle chosen=1, starved=1.
- Same stimulus with BPD_ARB_STARVE_EN undefined → chosen=0 for 100 cycles; io_in_ready[1] never high.
- Single valid on channel 2 (N_IN=3) at cycle 5, bits=0xA5 → io_out_valid=1, bits=0xA5, chosen=2 at cycle 6.
- io_out_ready=0 for 10 cycles with all channels valid → output stable, io_in_ready=0, wait_cnt values unchanged.
- Back-to-back: channel 0 streams 8 payloads with io_out_ready=1 → 8 outputs in 8 consecutive cycles, in order, with no bubble.
- Reset asserted while io_out_valid=1 → io_out_valid=0 immediately (asynchronously); after release, first output only after a new handshake.
